ht_stream_sort: RTL and testbench
=================================

# ht_stream_sort

Streaming, parametrised successor to the `ht` parallel sorter. It accepts a frame of up to DEPTH unsigned words over a valid/ready input stream and sorts the frame in place with an odd-even transposition network, one layer per cycle. Sort direction is ascending or descending and is chosen per frame. The block returns the sorted frame over a valid/ready output stream with a last marker. It sits between a packet source and downstream consumers that previously needed a full parallel `outdata` bus.

## Interface
Parameters:
- WIDTH, 5: data word width in bits, ≥1.
- DEPTH, 8: maximum frame length, ≥2.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts an input word.
- in_data  in  WIDTH  input word, unsigned.
- in_last  in  1  marks the final word of a frame.
- in_desc  in  1  direction: 1 = descending, 0 = ascending. Sampled with the first word of each frame.
- out_valid  out  1  sorted word present.
- out_ready  in  1  consumer accepts the sorted word.
- out_data  out  WIDTH  sorted word.
- out_last  out  1  marks the final sorted word of the frame.
- busy  out  1  high in SORT and DRAIN.

## Operation
- States: LOAD → SORT → DRAIN → LOAD.
- Storage: DEPTH-entry register array `r[0..DEPTH-1]`, element counter `cnt` of width $clog2(DEPTH+1), pass counter `pass`, and latched direction `desc_q`.
- **LOAD**
  - `in_ready`=1.
  - Each accepted word (in_valid & in_ready) is written to `r[cnt]` and increments `cnt`.
  - On the first word of a frame (`cnt`==0), `desc_q` ← in_desc.
  - The frame closes on an accepted word with in_last=1, or on acceptance of the DEPTH-th word, whichever comes first. in_last on the DEPTH-th word is redundant and harmless.
  - On close, unfilled entries `r[cnt..DEPTH-1]` are padded with a sentinel: all-ones if ascending, zero if descending. The state moves to SORT and `pass` is cleared.
- **SORT**
  - Exactly DEPTH cycles. `pass` counts 0..DEPTH-1.
  - Even `pass`: compare-exchange pairs (0,1), (2,3), …
  - Odd `pass`: compare-exchange pairs (1,2), (3,4), …
  - Ascending: swap when left > right. Descending: swap when left < right.
  - Equal values never swap.
  - After `pass`==DEPTH-1 the state moves to DRAIN.
- **DRAIN**
  - `out_valid`=1, `out_data`=`r[0]`.
  - `out_last`=1 when exactly one element remains to emit.
  - On handshake, the array shifts down by one (`r[i]` ← `r[i+1]`) and `cnt` decrements.
  - Only the original `cnt` elements are emitted. Sentinels are never output.
  - When the last word is accepted, the state returns to LOAD with `cnt`=0.
- **Arithmetic:** comparisons are unsigned over the full WIDTH.

## Timing
- Reset values: state=LOAD, `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `r[*]`=0, `cnt`=0, `pass`=0, `desc_q`=0.
- An async assert mid-frame aborts immediately; partial input and output are discarded.
- `in_ready` is a registered state decode. There is no combinational path from out_ready to in_ready.
- Latency: the closing word is accepted at edge t. SORT occupies edges t+1..t+DEPTH. `out_valid` rises after edge t+DEPTH.
- With out_ready held high, one word is emitted per cycle.
- Sustained frame period with no backpressure: n + DEPTH + n cycles for frame length n.
- out_ready low holds `out_data` and `out_last` stable. out_valid never drops before its handshake.
- `in_ready`=0 throughout SORT and DRAIN; in_valid there is ignored, and no input is lost because no handshake occurs.
- Single-element frame: in_last on the first word. SORT still runs DEPTH cycles, then one output with `out_last`=1.
- in_desc changes mid-frame have no effect.

## Structure
- The shared package `ht_pkg` holds:
  - the state enum (`ST_LOAD`, `ST_SORT`, `ST_DRAIN`);
  - a `cnt_w(depth)` function returning $clog2(depth+1).
- Sub-module `ht_cas`: a combinational compare-and-swap cell.
  - Parameter WIDTH.
  - Inputs `a`, `b`, `desc`; outputs `lo`, `hi` (ordered by direction).
  - Instantiated DEPTH-1 times in a generate loop; the even/odd layer is selected by `pass[0]`.
- The top level holds the FSM, counters, array and padding.

## Test plan
- Ascending full frame, DEPTH=8, WIDTH=5: input 7,3,31,0,12,3,9,1 with in_last on the 8th word → output 0,1,3,3,7,9,12,31; out_last on 31; out_valid first high 8 cycles after the closing handshake.
- Descending partial frame: in_desc=1, input 5,20,2 with in_last on 2 → exactly three outputs 20,5,2; out_last on 2; no zero sentinels emitted.
- Backpressure: same frame as the ascending case with out_ready toggling 1,0,0,1,… → out_data held stable while stalled; sequence unchanged; in_ready stays 0 until 31 is accepted.
- Sentinel collision: ascending, input 31,0,31 with in_last → output 0,31,31 (three words only).
- Reset mid-DRAIN: drive rst_n low after two outputs → out_valid and busy drop immediately, in_ready=1. The next frame 4,2 sorts to 2,4.
- Back-to-back frames, in_valid held high: frame A (asc 3,1) then frame B (desc 1,3) → A emits 1,3; B's first word is accepted only after A's last output; B emits 3,1.

Source files
------------

// File: rtl/ht_pkg.sv
// ht_pkg: shared state encoding and sizing helper for the ht stream sorter.
package ht_pkg;
  typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_DRAIN} st_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ht_cas.sv
// ht_cas: combinational compare-and-swap cell; lo comes first in the chosen sort order.
module ht_cas #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic swap;
  always_comb begin
    swap = desc ? (a < b) : (a > b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end
endmodule

// File: rtl/ht_stream_sort.sv
// ht_stream_sort: loads a frame, sorts it with an odd-even transposition network, streams it out.
module ht_stream_sort
  import ht_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_desc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = cnt_w(DEPTH);
  st_t              state;
  logic [WIDTH-1:0] r   [DEPTH];
  logic [WIDTH-1:0] srt [DEPTH];
  logic [WIDTH-1:0] lo  [DEPTH-1];
  logic [WIDTH-1:0] hi  [DEPTH-1];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    pass;
  logic             desc_q;
  logic             acc;
  logic             close;
  logic             dir;
  logic [WIDTH-1:0] pad;
  always_comb begin
    in_ready  = state == ST_LOAD;
    out_valid = state == ST_DRAIN;
    busy      = state != ST_LOAD;
    out_data  = r[0];
    out_last  = out_valid && cnt == CW'(1);
    acc       = in_valid && in_ready;
    close     = acc && (in_last || cnt == CW'(DEPTH - 1));
    dir       = cnt == '0 ? in_desc : desc_q;
    pad       = dir ? '0 : '1;
  end
  genvar i;
  for (i = 0; i < DEPTH - 1; i++) begin : g_cas
    ht_cas #(.WIDTH(WIDTH)) u_cas (
      .a   (r[i]),
      .b   (r[i+1]),
      .desc(desc_q),
      .lo  (lo[i]),
      .hi  (hi[i])
    );
  end
  // Even passes pair (0,1),(2,3)..; odd passes pair (1,2),(3,4)..; unpaired ends hold.
  for (i = 0; i < DEPTH; i++) begin : g_lane
    if (i == 0) begin : g_first
      assign srt[i] = pass[0] ? r[i] : lo[i];
    end else if (i == DEPTH - 1) begin : g_last
      assign srt[i] = (pass[0] != 1'(i % 2)) ? hi[i-1] : r[i];
    end else begin : g_mid
      assign srt[i] = (pass[0] == 1'(i % 2)) ? lo[i] : hi[i-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_LOAD;
      cnt    <= '0;
      pass   <= '0;
      desc_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) r[k] <= '0;
    end else begin
      case (state)
        ST_LOAD: if (acc) begin
          if (cnt == '0) desc_q <= in_desc;
          cnt <= cnt + CW'(1);
          for (int k = 0; k < DEPTH; k++)
            if (CW'(k) == cnt) r[k] <= in_data;
            else if (close && CW'(k) > cnt) r[k] <= pad;
          if (close) begin
            state <= ST_SORT;
            pass  <= '0;
          end
        end
        ST_SORT: begin
          for (int k = 0; k < DEPTH; k++) r[k] <= srt[k];
          pass <= pass + CW'(1);
          if (pass == CW'(DEPTH - 1)) state <= ST_DRAIN;
        end
        ST_DRAIN: if (out_ready) begin
          for (int k = 0; k < DEPTH - 1; k++) r[k] <= r[k+1];
          r[DEPTH-1] <= '0;
          cnt        <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_LOAD;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_ht_stream_sort.sv
// tb_ht_stream_sort: table-driven frames with a scoreboard of expected sorted words.
module tb_ht_stream_sort;
  typedef struct packed {
    logic [3:0]      len;
    logic            desc;
    logic [0:7][4:0] d;
    logic [0:7][4:0] e;
  } vec_t;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [4:0] in_data = '0;
  logic       in_last = 0;
  logic       in_desc = 0;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       out_last;
  logic       busy;
  int         n_pass = 0;
  int         n_tot = 0;
  int         cyc = 0;
  int         ph = 0;
  bit         bp = 0;
  int         first_acc = 0;
  int         close_cyc = 0;
  int         last_edge = 0;
  logic [5:0] sb[$];
  vec_t       tv[9];
  bit         stall_q = 0;
  logic [4:0] hd;
  logic       hl;
  ht_stream_sort #(.WIDTH(5), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_desc(in_desc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 3;
      out_ready = bp ? (ph == 0) : 1'b1;
    end
  end
  always @(negedge clk) begin
    logic [5:0] x;
    if (!rst_n) stall_q = 0;
    else begin
      if (stall_q) begin
        chk("stall hold data", out_data, hd);
        chk("stall hold last", out_last, hl);
        chk("stall hold valid", out_valid, 1);
      end
      if (out_valid) chk("in_ready low in drain", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("extra output", 1, 0);
        else begin
          x = sb.pop_front();
          chk("out_data", out_data, x[5:1]);
          chk("out_last", out_last, x[0]);
          if (out_last) last_edge = cyc + 1;
        end
      end
      stall_q = out_valid && !out_ready;
      hd = out_data;
      hl = out_last;
    end
  end
  task automatic send(input vec_t v, input bit hold);
    int to;
    for (int j = 0; j < int'(v.len); j++) begin
      in_valid = 1;
      in_data  = v.d[j];
      in_last  = (j == int'(v.len) - 1);
      in_desc  = (j == 0) ? v.desc : ~v.desc;
      to = 0;
      do begin
        @(negedge clk);
        to++;
      end while (!in_ready && to < 200);
      if (!in_ready) begin
        chk("in_ready timeout", 0, 1);
        in_valid = 0;
        return;
      end
      @(posedge clk);
      #1;
      if (j == 0) first_acc = cyc;
    end
    for (int j = 0; j < int'(v.len); j++) sb.push_back({v.e[j], j == int'(v.len) - 1});
    close_cyc = cyc;
    if (!hold) begin
      in_valid = 0;
      in_last  = 0;
    end
  endtask
  task automatic wait_drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    chk("drain complete", sb.size(), 0);
    @(posedge clk);
    #1;
    chk("idle in_ready", in_ready, 1);
    chk("idle busy", busy, 0);
  endtask
  initial begin
    tv[0] = '{4'd8, 1'b0, {5'd7, 5'd3, 5'd31, 5'd0, 5'd12, 5'd3, 5'd9, 5'd1},
                          {5'd0, 5'd1, 5'd3, 5'd3, 5'd7, 5'd9, 5'd12, 5'd31}};
    tv[1] = '{4'd3, 1'b1, {5'd5, 5'd20, 5'd2, 25'd0}, {5'd20, 5'd5, 5'd2, 25'd0}};
    tv[2] = '{4'd3, 1'b0, {5'd31, 5'd0, 5'd31, 25'd0}, {5'd0, 5'd31, 5'd31, 25'd0}};
    tv[3] = '{4'd1, 1'b0, {5'd17, 35'd0}, {5'd17, 35'd0}};
    tv[4] = '{4'd8, 1'b1, {5'd0, 5'd31, 5'd5, 5'd5, 5'd16, 5'd1, 5'd30, 5'd2},
                          {5'd31, 5'd30, 5'd16, 5'd5, 5'd5, 5'd2, 5'd1, 5'd0}};
    tv[5] = '{4'd1, 1'b1, {5'd0, 35'd0}, {5'd0, 35'd0}};
    tv[6] = '{4'd2, 1'b0, {5'd4, 5'd2, 30'd0}, {5'd2, 5'd4, 30'd0}};
    tv[7] = '{4'd2, 1'b0, {5'd3, 5'd1, 30'd0}, {5'd1, 5'd3, 30'd0}};
    tv[8] = '{4'd2, 1'b1, {5'd1, 5'd3, 30'd0}, {5'd3, 5'd1, 30'd0}};
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_last", out_last, 0);
    chk("reset out_data", out_data, 0);
    chk("reset busy", busy, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    send(tv[0], 0);
    chk("sort busy", busy, 1);
    chk("sort in_ready", in_ready, 0);
    chk("sort out_valid", out_valid, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("latency", cyc - close_cyc, 8);
    wait_drain();
    for (int i = 1; i < 7; i++) begin
      send(tv[i], 0);
      wait_drain();
    end
    bp = 1;
    send(tv[0], 0);
    wait_drain();
    bp = 0;
    send(tv[0], 0);
    for (int k = 0; k < 100 && sb.size() > 6; k++) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort out_data", out_data, 0);
    sb.delete();
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    send(tv[6], 0);
    wait_drain();
    send(tv[7], 1);
    send(tv[8], 0);
    chk("B accepted after A last", first_acc, last_edge + 1);
    wait_drain();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
